// File: rtl/store_commit_drain.sv
// store_commit_drain
//   Drain stage behind the store buffer. Committed stores are queued in
//   order and written to data memory one at a time over a req/ack port. Byte
//   enables and lane-replicated write data are built from the RISC-V store
//   width. Misaligned or illegal-width stores are retired without a memory
//   write and flagged with misalign. Entries are already committed, so no
//   flush input exists.
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   in_valid/in_ready            push handshake for a committed store
//   in_addr/in_data/in_width     store address, LSB-aligned data, funct3
//   in_rob                       ROB tag of the store
//   mem_req/mem_ack              memory write handshake
//   mem_addr/mem_wdata/mem_be    word address, lane data, byte enables
//   done_valid/done_rob          one-cycle retire pulse and its tag
//   misalign                     retire pulse was a dropped store
//   empty/count                  queue occupancy
module store_commit_drain #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 6,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_data,
    input  logic [2:0]       in_width,
    input  logic [ROB_W-1:0] in_rob,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    output logic             done_valid,
    output logic [ROB_W-1:0] done_rob,
    output logic             misalign,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

    // A head store that can never be written: misaligned SH/SW or unknown width.
    function automatic logic head_illegal(input logic [2:0] width, input logic [1:0] a);
        logic bad;
        case (width)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Returns {be, wdata} with the store data replicated across all lanes.
    function automatic logic [35:0] lane_form(input logic [2:0] width, input logic [1:0] a,
                                              input logic [31:0] data);
        logic [3:0]  be;
        logic [31:0] wd;
        case (width)
            3'b000: begin
                be = 4'b0001 << a;
                wd = {4{data[7:0]}};
            end
            3'b001: begin
                be = a[1] ? 4'b1100 : 4'b0011;
                wd = {2{data[15:0]}};
            end
            3'b010: begin
                be = 4'b1111;
                wd = data;
            end
            default: begin
                be = 4'b0000;
                wd = 32'h0000_0000;
            end
        endcase
        return {be, wd};
    endfunction

    logic [31:0]      addr_q  [DEPTH];
    logic [31:0]      addr_d  [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [31:0]      data_d  [DEPTH];
    logic [2:0]       width_q [DEPTH];
    logic [2:0]       width_d [DEPTH];
    logic [ROB_W-1:0] rob_q   [DEPTH];
    logic [ROB_W-1:0] rob_d   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic             done_valid_q, done_valid_d, misalign_q, misalign_d;
    logic [ROB_W-1:0] done_rob_q, done_rob_d;

    logic             push_s, pop_s, in_ready_s;
    logic [35:0]      lanes_s;

    // No full bypass: a pop in the same cycle does not open the queue to a push.
    assign in_ready_s = (count_q != CNT_W'(DEPTH));
    assign push_s     = in_valid && in_ready_s;

    // Queue storage, pointers and occupancy.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        width_d = width_q;
        rob_d   = rob_q;
        if (push_s) begin
            addr_d[tail_q]  = in_addr;
            data_d[tail_q]  = in_data;
            width_d[tail_q] = in_width;
            rob_d[tail_q]   = in_rob;
            tail_d          = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Drain FSM: decide head fate in IDLE, hold the request in REQ until ack.
    always_comb begin
        state_d      = state_q;
        pop_s        = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        done_valid_d = 1'b0;
        misalign_d   = 1'b0;
        done_rob_d   = '0;
        lanes_s      = lane_form(width_q[head_q], addr_q[head_q][1:0], data_q[head_q]);
        case (state_q)
            IDLE: begin
                if (count_q == CNT_W'(0)) begin
                    state_d = IDLE;
                end else if (head_illegal(width_q[head_q], addr_q[head_q][1:0])) begin
                    pop_s        = 1'b1;
                    done_valid_d = 1'b1;
                    misalign_d   = 1'b1;
                    done_rob_d   = rob_q[head_q];
                end else begin
                    state_d     = REQ;
                    mem_addr_d  = {addr_q[head_q][31:2], 2'b00};
                    mem_be_d    = lanes_s[35:32];
                    mem_wdata_d = lanes_s[31:0];
                end
            end
            REQ: begin
                if (mem_ack) begin
                    pop_s        = 1'b1;
                    state_d      = IDLE;
                    done_valid_d = 1'b1;
                    done_rob_d   = rob_q[head_q];
                    mem_addr_d   = 32'h0000_0000;
                    mem_wdata_d  = 32'h0000_0000;
                    mem_be_d     = 4'b0000;
                end else begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_addr_d  = 32'h0000_0000;
                mem_wdata_d = 32'h0000_0000;
                mem_be_d    = 4'b0000;
            end
        endcase
    end

    // State, queue and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= 32'h0000_0000;
                data_q[i]  <= 32'h0000_0000;
                width_q[i] <= 3'b000;
                rob_q[i]   <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            mem_be_q     <= 4'b0000;
            done_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            done_rob_q   <= '0;
        end else begin
            addr_q       <= addr_d;
            data_q       <= data_d;
            width_q      <= width_d;
            rob_q        <= rob_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            done_valid_q <= done_valid_d;
            misalign_q   <= misalign_d;
            done_rob_q   <= done_rob_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign mem_req    = (state_q == REQ);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign done_valid = done_valid_q;
    assign done_rob   = done_rob_q;
    assign misalign   = misalign_q;
    assign empty      = (count_q == CNT_W'(0));
    assign count      = count_q;

endmodule

// File: tb/tb_store_commit_drain.sv
// Directed bench for store_commit_drain: inputs change 1 time unit after the
// rising edge, outputs are checked at that same point.
module tb_store_commit_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [2:0]  in_width;
    logic [5:0]  in_rob;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done_valid;
    logic [5:0]  done_rob;
    logic        misalign;
    logic        empty;
    logic [2:0]  count;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    store_commit_drain #(.DEPTH(4), .ROB_W(6)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_width(in_width), .in_rob(in_rob),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack),
        .done_valid(done_valid), .done_rob(done_rob), .misalign(misalign),
        .empty(empty), .count(count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] w, input logic [5:0] r);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_width = w;
        in_rob   = r;
        step();
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for the next retire pulse and checks its tag and kind.
    task automatic expect_done(input string tag, input logic [5:0] r, input logic mis,
                               input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (done_valid) seen = 1'b1;
        end
        check({tag, "_seen"}, {31'd0, done_valid}, 32'd1);
        if (seen) begin
            check({tag, "_rob"}, {26'd0, done_rob}, {26'd0, r});
            check({tag, "_mis"}, {31'd0, misalign}, {31'd0, mis});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_addr  = 32'h0;
        in_data  = 32'h0;
        in_width = 3'b000;
        in_rob   = 6'd0;
        mem_ack  = 1'b0;
        #3;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_done", {31'd0, done_valid}, 32'd0);
        check("rst_tag", {26'd0, done_rob}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // SW aligned, ack tied high: one request cycle then retire.
        mem_ack = 1'b1;
        push_one(32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 6'd5);
        check("sw_count", {29'd0, count}, 32'd1);
        step();
        check("sw_req", {31'd0, mem_req}, 32'd1);
        check("sw_addr", mem_addr, 32'h0000_0100);
        check("sw_be", {28'd0, mem_be}, 32'hF);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        check("sw_done", {31'd0, done_valid}, 32'd1);
        check("sw_tag", {26'd0, done_rob}, 32'd5);
        check("sw_mis", {31'd0, misalign}, 32'd0);
        check("sw_req_low", {31'd0, mem_req}, 32'd0);
        check("sw_addr_zero", mem_addr, 32'd0);
        check("sw_empty", {31'd0, empty}, 32'd1);
        step();
        check("sw_pulse", {31'd0, done_valid}, 32'd0);
        check("sw_tag_zero", {26'd0, done_rob}, 32'd0);

        // SB at byte 3.
        push_one(32'h0000_0103, 32'h0000_00AB, 3'b000, 6'd2);
        step();
        check("sb_addr", mem_addr, 32'h0000_0100);
        check("sb_be", {28'd0, mem_be}, 32'h8);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        expect_done("sb", 6'd2, 1'b0, 4);

        // SH at upper halfword.
        push_one(32'h0000_0102, 32'h1234_5678, 3'b001, 6'd3);
        step();
        check("sh_addr", mem_addr, 32'h0000_0100);
        check("sh_be", {28'd0, mem_be}, 32'hC);
        check("sh_wdata", mem_wdata, 32'h5678_5678);
        expect_done("sh", 6'd3, 1'b0, 4);

        // Illegal heads are dropped without a request.
        push_one(32'h0000_0201, 32'h0000_1111, 3'b001, 6'd7);
        check("mis_sh_noreq", {31'd0, mem_req}, 32'd0);
        expect_done("mis_sh", 6'd7, 1'b1, 4);
        check("mis_sh_noreq2", {31'd0, mem_req}, 32'd0);
        push_one(32'h0000_0302, 32'h0000_2222, 3'b010, 6'd6);
        expect_done("mis_sw", 6'd6, 1'b1, 4);
        push_one(32'h0000_0400, 32'h0000_3333, 3'b011, 6'd8);
        expect_done("mis_w", 6'd8, 1'b1, 4);

        // Fill with ack low, overflow push ignored, then drain in order.
        mem_ack = 1'b0;
        push_one(32'h0000_0010, 32'h1, 3'b010, 6'd1);
        push_one(32'h0000_0020, 32'h2, 3'b010, 6'd2);
        push_one(32'h0000_0030, 32'h3, 3'b010, 6'd3);
        push_one(32'h0000_0040, 32'h4, 3'b010, 6'd4);
        check("full_count", {29'd0, count}, 32'd4);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        push_one(32'h0000_0050, 32'h5, 3'b010, 6'd9);
        check("over_count", {29'd0, count}, 32'd4);
        check("hold_req", {31'd0, mem_req}, 32'd1);
        check("hold_addr", mem_addr, 32'h0000_0010);
        mem_ack = 1'b1;
        expect_done("ord1", 6'd1, 1'b0, 6);
        expect_done("ord2", 6'd2, 1'b0, 6);
        expect_done("ord3", 6'd3, 1'b0, 6);
        expect_done("ord4", 6'd4, 1'b0, 6);
        check("ord_empty", {31'd0, empty}, 32'd1);

        // Push offered in the ack cycle of a full queue: waits for in_ready, drains last.
        mem_ack = 1'b0;
        push_one(32'h0000_0110, 32'h11, 3'b010, 6'd11);
        push_one(32'h0000_0120, 32'h12, 3'b010, 6'd12);
        push_one(32'h0000_0130, 32'h13, 3'b010, 6'd13);
        push_one(32'h0000_0140, 32'h14, 3'b010, 6'd14);
        in_valid = 1'b1;
        in_addr  = 32'h0000_0150;
        in_data  = 32'h15;
        in_width = 3'b010;
        in_rob   = 6'd15;
        mem_ack  = 1'b1;
        step();
        check("fa_tag", {26'd0, done_rob}, 32'd11);
        check("fa_count", {29'd0, count}, 32'd3);
        check("fa_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("fb_count", {29'd0, count}, 32'd4);
        expect_done("f12", 6'd12, 1'b0, 6);
        expect_done("f13", 6'd13, 1'b0, 6);
        expect_done("f14", 6'd14, 1'b0, 6);
        expect_done("f15", 6'd15, 1'b0, 6);
        check("f_empty", {31'd0, empty}, 32'd1);

        // Simultaneous push and pop keeps count unchanged.
        mem_ack = 1'b0;
        push_one(32'h0000_0210, 32'h21, 3'b010, 6'd21);
        step();
        in_valid = 1'b1;
        in_addr  = 32'h0000_0220;
        in_data  = 32'h22;
        in_width = 3'b010;
        in_rob   = 6'd22;
        mem_ack  = 1'b1;
        step();
        in_valid = 1'b0;
        check("pp_tag", {26'd0, done_rob}, 32'd21);
        check("pp_count", {29'd0, count}, 32'd1);
        expect_done("pp22", 6'd22, 1'b0, 4);

        // Reset while a request is outstanding.
        mem_ack = 1'b0;
        push_one(32'h0000_0300, 32'h30, 3'b010, 6'd30);
        step();
        check("mr_req", {31'd0, mem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mr_req_low", {31'd0, mem_req}, 32'd0);
        check("mr_count", {29'd0, count}, 32'd0);
        check("mr_empty", {31'd0, empty}, 32'd1);
        check("mr_ready", {31'd0, in_ready}, 32'd1);
        check("mr_be", {28'd0, mem_be}, 32'd0);
        step();
        reset = 1'b0;
        step();
        check("mr_after_req", {31'd0, mem_req}, 32'd0);
        check("mr_after_done", {31'd0, done_valid}, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
